octal_ram_cfg_seq: RTL
======================

Name: octal_ram_cfg_seq

Overview:
- Sequences Octal PSRAM mode-register configuration after reset or on request.
- Steps an external configuration table index (oCfgNo) through the write entries (MRW), then the readback entries (MRR).
- Issues each entry as a command to the OPI command engine and reports readback data.
- Sits between the system reset/start logic and the OPI command engine, ahead of normal memory traffic.

Parameters:
- WR_NUM, 4, number of table entries issued as MRW (indices 0..WR_NUM-1).
- RD_NUM, 6, number of table entries issued as MRR (indices WR_NUM..WR_NUM+RD_NUM-1).
- PWRUP_CYC, 20000, power-up wait in clocks (150 us at 133 MHz); applied once after reset.
- GAP_CYC, 4, idle clocks between consecutive commands (tCPH margin).
- RSP_TIMEOUT, 64, maximum clocks from MRR acceptance to iRspValid.

Ports:
- iClk  in  1  system clock.
- iRst_N  in  1  asynchronous active-low reset.
- iStart  in  1  start pulse; sampled only in IDLE, DONE, ERR.
- oCfgNo  out  8  table index driven to the configuration table.
- iCfgAddr  in  8  table mode-register address (combinational from oCfgNo).
- iCfgData  in  8  table mode-register data.
- oCmdValid  out  1  command valid.
- iCmdReady  in  1  command engine ready.
- oCmdWrite  out  1  1=MRW, 0=MRR.
- oCmdAddr  out  8  MA[7:0].
- oCmdData  out  8  OP[7:0]; 0 for MRR.
- iRspValid  in  1  MRR data valid, single-cycle.
- iRspData  in  8  MRR data.
- oRdValid  out  1  one-cycle pulse per completed MRR.
- oRdAddr  out  8  MA of that MRR.
- oRdData  out  8  captured readback.
- oBusy  out  1  high in any state except IDLE/DONE/ERR.
- oDone  out  1  level; sequence completed.
- oErr  out  1  level; timeout (or mismatch, see feature).

Behaviour:
- Reset: all outputs 0, state IDLE, power-up flag cleared. An asynchronous reset mid-sequence aborts at once; oCmdValid drops without waiting for handshake.
- States: IDLE, PWRUP, LOAD, ISSUE, WAIT_RSP, GAP, DONE, ERR.
- IDLE/DONE/ERR + iStart:
  - oDone and oErr clear; oCfgNo=0.
  - Go to PWRUP if the power-up flag is clear, else LOAD.
- PWRUP: count PWRUP_CYC clocks, set the flag, then go to LOAD.
- LOAD: one clock. Register iCfgAddr→oCmdAddr. oCmdWrite=(oCfgNo<WR_NUM). oCmdData=iCfgData for writes, else 0. Go to ISSUE.
- ISSUE:
  - oCmdValid=1; addr/data/write held stable until iCmdReady=1 in the same cycle (transfer).
  - On transfer: oCmdValid=0 next clock. MRW → GAP; MRR → WAIT_RSP with the timeout counter cleared.
- WAIT_RSP:
  - On iRspValid: capture iRspData. Next clock pulse oRdValid with oRdAddr/oRdData, then go to GAP.
  - Counter reaching RSP_TIMEOUT with no response → ERR.
  - iRspValid outside WAIT_RSP is ignored.
- GAP: wait GAP_CYC clocks.
  - If oCfgNo==WR_NUM+RD_NUM-1 → DONE (oDone=1).
  - Else oCfgNo+1 → LOAD.
- ERR: oErr=1, oBusy=0, oCfgNo frozen at the failing index.
- Command count: WR_NUM+RD_NUM commands per sequence in index order; oCfgNo never exceeds WR_NUM+RD_NUM-1.
- Counters: PWRUP counter 16 bits, gap/timeout counters 8 bits; no wrap inside any state.
- iStart during busy: ignored, not queued.

Optional Feature:
- Macro: OCTAL_RAM_CFG_VERIFY_EN.
- With it:
  - Shadow registers hold the OP written to MA 00, 04, 08.
  - Each MRR of those MAs compares (readback & mask) against (shadow & mask).
  - Mismatch → ERR after the oRdValid pulse.
- Without it: no shadows or compare; oErr only on timeout.

Decomposition:
- Package octal_ram_cfg_pkg:
  - state enum.
  - MA constants 8'h00/8'h04/8'h08.
  - compare masks: MA00 8'h3F, MA04 8'hE0, MA08 8'h0F.
  - command-type constants.
- Sub-module octal_ram_cfg_timer: loadable down-counter shared by PWRUP, GAP and timeout.

Test Plan:
- Reset release, iStart, iCmdReady tied 1, responses returned after 3 clocks:
  - 20000-clock wait.
  - MRW (00,08), (04,40), (06,F0), (08,00).
  - MRR to 00,01,02,03,04,08.
  - Six oRdValid pulses, then oDone=1.
- iCmdReady held low 10 clocks during the second command → oCmdValid, oCmdAddr=04, oCmdData=40 stable throughout; single transfer.
- No iRspValid for the MRR to MA 01 → ERR exactly 64 clocks after acceptance; oErr=1, oCfgNo=5.
- Second iStart after DONE → no power-up wait; first oCmdValid within 2 clocks.
- iRst_N asserted while in WAIT_RSP → all outputs 0 asynchronously; restart begins with PWRUP.
- VERIFY_EN, MA04 readback 8'h20 → oRdValid with data 20, then oErr=1; same stimulus with the macro off → oDone=1.

Source files
------------

// File: rtl/octal_ram_cfg_pkg.sv
// Shared types and constants for the Octal PSRAM mode-register configuration sequencer.
package octal_ram_cfg_pkg;

  localparam int unsigned CFG_WR_NUM      = 4;
  localparam int unsigned CFG_RD_NUM      = 6;
  localparam int unsigned CFG_PWRUP_CYC   = 20000;
  localparam int unsigned CFG_GAP_CYC     = 4;
  localparam int unsigned CFG_RSP_TIMEOUT = 64;
  localparam int unsigned TMR_W           = 16;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [BYTE_W-1:0] MA_00 = 8'h00;
  localparam logic [BYTE_W-1:0] MA_04 = 8'h04;
  localparam logic [BYTE_W-1:0] MA_08 = 8'h08;

  localparam logic [BYTE_W-1:0] MASK_MA00 = 8'h3F;
  localparam logic [BYTE_W-1:0] MASK_MA04 = 8'hE0;
  localparam logic [BYTE_W-1:0] MASK_MA08 = 8'h0F;

  localparam logic CMD_MRW = 1'b1;
  localparam logic CMD_MRR = 1'b0;

  // Readback compare mask per shadowed mode register; zero means not compared.
  function automatic logic [BYTE_W-1:0] cmp_mask(input logic [BYTE_W-1:0] ma);
    case (ma)
      MA_00:   cmp_mask = MASK_MA00;
      MA_04:   cmp_mask = MASK_MA04;
      MA_08:   cmp_mask = MASK_MA08;
      default: cmp_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/octal_ram_cfg_timer.sv
// Loadable saturating down-counter shared by the power-up, gap and response-timeout waits.
module octal_ram_cfg_timer
  import octal_ram_cfg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [TMR_W-1:0] r_cnt;

  // Load wins; otherwise count down and hold at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/octal_ram_cfg_seq.sv
// Octal PSRAM mode-register configuration sequencer: MRW table entries, then MRR readbacks.
// Optional readback verification of MA 00/04/08 enabled by OCTAL_RAM_CFG_VERIFY_EN.
module octal_ram_cfg_seq
  import octal_ram_cfg_pkg::*;
#(
  parameter int unsigned WR_NUM      = CFG_WR_NUM,
  parameter int unsigned RD_NUM      = CFG_RD_NUM,
  parameter int unsigned PWRUP_CYC   = CFG_PWRUP_CYC,
  parameter int unsigned GAP_CYC     = CFG_GAP_CYC,
  parameter int unsigned RSP_TIMEOUT = CFG_RSP_TIMEOUT
)(
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic       iStart,
  output logic [7:0] oCfgNo,
  input  logic [7:0] iCfgAddr,
  input  logic [7:0] iCfgData,
  output logic       oCmdValid,
  input  logic       iCmdReady,
  output logic       oCmdWrite,
  output logic [7:0] oCmdAddr,
  output logic [7:0] oCmdData,
  input  logic       iRspValid,
  input  logic [7:0] iRspData,
  output logic       oRdValid,
  output logic [7:0] oRdAddr,
  output logic [7:0] oRdData,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam logic [TMR_W-1:0]  PWRUP_LD = TMR_W'(PWRUP_CYC - 1);
  localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0]  RSP_LD   = TMR_W'(RSP_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(WR_NUM + RD_NUM - 1);

  state_e           r_state;
  logic             r_pwrup_done;
  logic             r_mis;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_is_wr;
  logic             w_mis;

  assign w_is_wr = (32'(oCfgNo) < WR_NUM);

  // Reload the shared timer on entry to each timed state.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (iStart) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = PWRUP_LD;
        end
      end
      ST_ISSUE: begin
        if (iCmdReady) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (oCmdWrite == CMD_MRW) ? GAP_LD : RSP_LD;
        end
      end
      ST_WAIT_RSP: begin
        if (iRspValid) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = GAP_LD;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  octal_ram_cfg_timer u_timer (
    .i_clk      (iClk),
    .i_rst_n    (iRst_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero_c   (w_tmr_zero)
  );

`ifdef OCTAL_RAM_CFG_VERIFY_EN
  logic [7:0] r_shadow00;
  logic [7:0] r_shadow04;
  logic [7:0] r_shadow08;

  // Remember the OP written to each verified mode register.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_shadow00 <= '0;
      r_shadow04 <= '0;
      r_shadow08 <= '0;
    end else if (r_state == ST_ISSUE && iCmdReady && oCmdWrite == CMD_MRW) begin
      case (oCmdAddr)
        MA_00:   r_shadow00 <= oCmdData;
        MA_04:   r_shadow04 <= oCmdData;
        MA_08:   r_shadow08 <= oCmdData;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mis = 1'b0;
    case (oCmdAddr)
      MA_00:   w_mis = ((iRspData ^ r_shadow00) & cmp_mask(oCmdAddr)) != 8'h00;
      MA_04:   w_mis = ((iRspData ^ r_shadow04) & cmp_mask(oCmdAddr)) != 8'h00;
      MA_08:   w_mis = ((iRspData ^ r_shadow08) & cmp_mask(oCmdAddr)) != 8'h00;
      default: w_mis = 1'b0;
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  // Sequencer state and registered outputs.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state      <= ST_IDLE;
      r_pwrup_done <= 1'b0;
      r_mis        <= 1'b0;
      oCfgNo       <= '0;
      oCmdValid    <= 1'b0;
      oCmdWrite    <= 1'b0;
      oCmdAddr     <= '0;
      oCmdData     <= '0;
      oRdValid     <= 1'b0;
      oRdAddr      <= '0;
      oRdData      <= '0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oErr         <= 1'b0;
    end else begin
      oRdValid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (iStart) begin
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oCfgNo  <= '0;
            oBusy   <= 1'b1;
            r_mis   <= 1'b0;
            r_state <= r_pwrup_done ? ST_LOAD : ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (w_tmr_zero) begin
            r_pwrup_done <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          oCmdAddr  <= iCfgAddr;
          oCmdWrite <= w_is_wr ? CMD_MRW : CMD_MRR;
          oCmdData  <= w_is_wr ? iCfgData : 8'h00;
          oCmdValid <= 1'b1;
          r_state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (iCmdReady) begin
            oCmdValid <= 1'b0;
            r_state   <= (oCmdWrite == CMD_MRW) ? ST_GAP : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (iRspValid) begin
            oRdValid <= 1'b1;
            oRdAddr  <= oCmdAddr;
            oRdData  <= iRspData;
            r_mis    <= w_mis;
            r_state  <= ST_GAP;
          end else if (w_tmr_zero) begin
            oErr    <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= ST_ERR;
          end
        end
        ST_GAP: begin
          // A failed readback compare aborts right after its oRdValid pulse.
          if (r_mis) begin
            oErr    <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= ST_ERR;
          end else if (w_tmr_zero) begin
            if (oCfgNo == LAST_IDX) begin
              oDone   <= 1'b1;
              oBusy   <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              oCfgNo  <= oCfgNo + 8'd1;
              r_state <= ST_LOAD;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
